alu_muldiv: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, placed beside the single-cycle ALU in EX.
//   It executes MIPS mult/multu/div/divu iteratively, one bit per clock, under a start/busy/done

---
 rtl/alu_muldiv.sv | 211 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with HI/LO registers.
// Executes mult/multu/div/divu one bit per clock under a start/busy/done
// handshake, and services mfhi/mflo/mthi/mtlo.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         issue request, sampled only in IDLE
//   control       funct code (24 mult, 25 multu, 26 div, 27 divu,
//                 16 mfhi, 17 mthi, 18 mflo, 19 mtlo)
//   read1         rs operand: multiplicand / dividend / mthi,mtlo data
//   foutput       rt operand: multiplier / divisor
//   out           combinational hi (control==16), lo (control==18), else 0
//   hi, lo        HI/LO registers
//   busy          high while an operation is in flight
//   done          one-cycle pulse when hi/lo take a mult/div result
//   div_by_zero   set by a div/divu with a zero divisor, cleared on next accept
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       control,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] foutput,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned W2  = 2 * WIDTH;
    localparam int unsigned WP1 = WIDTH + 1;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_DIVU  = 6'd27;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W2-1:0]   acc_q, acc_d;      // mult: {partial, multiplier}; div: {rem, dividend/quotient}
    logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] opa_q, opa_d;     // raw dividend, for the divide-by-zero result
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;      // negate product / quotient
    logic            rneg_q, rneg_d;    // negate remainder
    logic            bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic            busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic            is_md, is_sgn, sa, sb;
    logic [WIDTH-1:0] ma, mb;
    logic [WP1-1:0]  sum_w, rem_sh, diff;
    logic            ge;
    logic [W2-1:0]   mul_next, div_next, step, prod;
    logic [WIDTH-1:0] quo_c, rem_c;

    // One shift-add or restoring shift-subtract iteration on the accumulator.
    always_comb begin
        sum_w    = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : WP1'(0));
        mul_next = {sum_w, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opb_q};
        ge       = ~diff[WIDTH];
        div_next = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        step     = is_div_q ? div_next : mul_next;
        prod     = neg_q ? (~step + W2'(1)) : step;
        quo_c    = neg_q ? (~step[WIDTH-1:0] + WIDTH'(1)) : step[WIDTH-1:0];
        rem_c    = rneg_q ? (~step[W2-1:WIDTH] + WIDTH'(1)) : step[W2-1:WIDTH];
    end

    // Next-state and register updates.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        opa_d    = opa_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        is_md  = (control >= F_MULT) && (control <= F_DIVU);
        is_sgn = ~control[0];
        sa     = is_sgn & read1[WIDTH-1];
        sb     = is_sgn & foutput[WIDTH-1];
        ma     = sa ? (~read1 + WIDTH'(1)) : read1;
        mb     = sb ? (~foutput + WIDTH'(1)) : foutput;

        case (state_q)
            S_IDLE: begin
                if (start && is_md) begin
                    state_d  = S_RUN;
                    count_d  = CW'(WIDTH);
                    is_div_d = control[1];
                    neg_d    = sa ^ sb;
                    rneg_d   = control[1] & sa;
                    bzero_d  = (foutput == '0);
                    opa_d    = read1;
                    dbz_d    = 1'b0;
                    if (control[1]) begin
                        acc_d = {WIDTH'(0), ma};
                        opb_d = mb;
                    end else begin
                        acc_d = {WIDTH'(0), mb};
                        opb_d = ma;
                    end
                end else if (start && control == F_MTHI) begin
                    hi_d = read1;
                end else if (start && control == F_MTLO) begin
                    lo_d = read1;
                end
            end
            S_RUN: begin
                acc_d   = step;
                count_d = count_q - CW'(1);
                if (count_q == CW'(2)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Final iteration is folded into the result write.
                acc_d   = step;
                count_d = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod[W2-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d = opa_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_c;
                    lo_d = quo_c;
                end
                dbz_d = is_div_q & bzero_q;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            opa_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            opa_q    <= opa_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    // mfhi/mflo read path.
    always_comb begin
        out = '0;
        if (control == F_MFHI) begin
            out = hi_q;
        end else if (control == F_MFLO) begin
            out = lo_q;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32, plus a small signed/unsigned sweep
// against a 64-bit arithmetic reference.
module tb_alu_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  control;
    logic [31:0] read1;
    logic [31:0] foutput;
    logic [31:0] dut_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .control(control),
        .read1(read1), .foutput(foutput), .out(dut_out), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, scramble operands after accept, wait for done.
    task automatic run_op(input string tag, input logic [5:0] c,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        start = 1'b1; control = c; read1 = a; foutput = b;
        tick();
        start = 1'b0; read1 = $urandom; foutput = $urandom; control = 6'd0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd32);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        longint la, lb, r;
        logic [63:0] v;
        if (c[0]) begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end
        if (!c[1]) begin
            v  = 64'(la * lb);
            eh = v[63:32];
            el = v[31:0];
        end else begin
            v  = 64'(la / lb);
            el = v[31:0];
            r  = la % lb;
            v  = 64'(r);
            eh = v[31:0];
        end
    endtask

    initial begin
        logic [31:0] ra, rb, eh, el;
        logic [5:0]  rc;

        start = 1'b0; control = 6'd0; read1 = '0; foutput = '0;
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        // Signed and unsigned multiply, signed divide
        run_op("mult", 6'd24, 32'hFFFF_FFFF, 32'd2);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);
        run_op("multu", 6'd25, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        tick();
        chk("done_pulse_one_cycle", 32'(done), 32'd0);
        run_op("div", 6'd26, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero then a normal divu clears the flag
        run_op("divu0", 6'd27, 32'd5, 32'd0);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd5);
        chk("divu0_dbz", 32'(div_by_zero), 32'd1);
        run_op("divu", 6'd27, 32'd7, 32'd2);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        chk("divu_dbz", 32'(div_by_zero), 32'd0);

        // Signed divide by zero keeps the raw dividend
        run_op("div0", 6'd26, 32'hFFFF_FFF9, 32'd0);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'hFFFF_FFF9);
        chk("div0_dbz", 32'(div_by_zero), 32'd1);

        // Signed overflow
        run_op("ovf", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        chk("ovf_dbz", 32'(div_by_zero), 32'd0);

        // Start during RUN is dropped; mfhi reads old hi while busy
        start = 1'b1; control = 6'd24; read1 = 32'd1000; foutput = 32'd3;
        tick();
        start = 1'b0; control = 6'd0;
        repeat (5) tick();
        start = 1'b1; control = 6'd24; read1 = 32'd9; foutput = 32'd9;
        tick();
        start = 1'b0; control = 6'd16;
        #1;
        chk("mfhi_busy_out", dut_out, 32'd0);
        chk("hi_stable_busy", hi, 32'd0);
        control = 6'd0;
        begin
            int lat;
            lat = 0;
            while (!done && lat < 40) begin
                tick();
                lat++;
            end
            chk("drop_lat", 32'(lat), 32'd26);
        end
        chk("drop_lo", lo, 32'd3000);
        chk("drop_hi", hi, 32'd0);
        tick();
        chk("drop_no_second", 32'(busy), 32'd0);

        // Async reset in the middle of a divide
        start = 1'b1; control = 6'd27; read1 = 32'd100; foutput = 32'd7;
        tick();
        start = 1'b0; control = 6'd0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_no_done", 32'(done), 32'd0);

        // mthi/mtlo and the out mux; mfhi issue is a no-op
        start = 1'b1; control = 6'd17; read1 = 32'h1234;
        tick();
        start = 1'b0;
        chk("mthi_done", 32'(done), 32'd0);
        chk("mthi_busy", 32'(busy), 32'd0);
        control = 6'd16;
        #1;
        chk("mfhi_out", dut_out, 32'h1234);
        start = 1'b1; control = 6'd19; read1 = 32'hABCD;
        tick();
        start = 1'b0; control = 6'd18;
        #1;
        chk("mflo_out", dut_out, 32'hABCD);
        chk("mtlo_hi_kept", hi, 32'h1234);
        start = 1'b1; control = 6'd16;
        tick();
        start = 1'b0;
        chk("mfhi_start_idle", 32'(busy), 32'd0);
        control = 6'd24;
        #1;
        chk("out_other_zero", dut_out, 32'd0);

        // Sweep against the reference
        for (int i = 0; i < 8; i++) begin
            rc = 6'(24 + (i % 4));
            ra = $urandom;
            rb = $urandom;
            if (i >= 4) rb = rb >> (i * 6);
            if (rb == 32'd0) rb = 32'd3;
            model(rc, ra, rb, eh, el);
            run_op("sweep", rc, ra, rb);
            chk("sweep_hi", hi, eh);
            chk("sweep_lo", lo, el);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
